// File: rtl/encoder_16_to_4_arb_pkg.sv
// Shared definitions for the 16-to-4 arbitrating encoder.
package encoder_16_to_4_arb_pkg;

    localparam int NUM_REQ = 16;
    localparam int IDX_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // One-hot mask for a granted index, used to form the acknowledge.
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/encoder_16_to_4_arb_if.sv
// Request / grant / acknowledge bundle between the encoder and its consumer.
// The encoder side uses the master modport, the requester/consumer side the slave.
interface encoder_16_to_4_arb_if;
    import encoder_16_to_4_arb_pkg::*;

    logic [NUM_REQ-1:0] encoderInput;
    logic [IDX_W-1:0]   encoderOutput;
    logic               outValid;
    logic               outReady;
    logic [NUM_REQ-1:0] reqAck;

    modport master (
        input  encoderInput,
        input  outReady,
        output encoderOutput,
        output outValid,
        output reqAck
    );

    modport slave (
        output encoderInput,
        output outReady,
        input  encoderOutput,
        input  outValid,
        input  reqAck
    );

endinterface

// File: rtl/encoder_16_to_4_arb_priority_pick_16.sv
// Combinational pick of one active request: the first set bit at or above
// start_ptr, searching upward and wrapping from 15 to 0.
module priority_pick_16
    import encoder_16_to_4_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] vec,
    input  logic [IDX_W-1:0]   start_ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Walk the 16 positions from the start pointer; the first hit wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = start_ptr + i[IDX_W-1:0];
            if (!any && vec[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder_16_to_4_arb.sv
// Registered 16-to-4 encoder with arbitration and valid/ready grant handshake.
// Optional feature macro: ENCODER_ROUND_ROBIN_EN
//   defined   -> rotating priority, search starts after the last accepted index
//   undefined -> fixed priority, lowest index wins, no pointer register
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant outstanding; sample requests and register a winner
// HOLD  | grant presented on encoderOutput/outValid, waiting for outReady
module encoder_16_to_4_arb
    import encoder_16_to_4_arb_pkg::*;
(
    input  logic clk,
    input  logic clr,
    encoder_16_to_4_arb_if.master bus
);

    state_t             state;
    logic [IDX_W-1:0]   enc_q;
    logic               valid_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [IDX_W-1:0]   start_ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

`ifdef ENCODER_ROUND_ROBIN_EN
    logic [IDX_W-1:0]   ptr_q;
    assign start_ptr = ptr_q;
`else
    assign start_ptr = '0;
`endif

    priority_pick_16 u_pick (
        .vec       (bus.encoderInput),
        .start_ptr (start_ptr),
        .idx       (pick_idx),
        .any       (pick_any)
    );

    // Grant FSM: capture a winner in IDLE, hold it until accepted, then
    // pulse the acknowledge and force one IDLE cycle before the next grant.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= IDLE;
            enc_q   <= '0;
            valid_q <= 1'b0;
            ack_q   <= '0;
`ifdef ENCODER_ROUND_ROBIN_EN
            ptr_q   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ack_q <= '0;
                    if (pick_any) begin
                        enc_q   <= pick_idx;
                        valid_q <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.outReady) begin
                        ack_q   <= idx_to_onehot(enc_q);
                        valid_q <= 1'b0;
                        state   <= IDLE;
`ifdef ENCODER_ROUND_ROBIN_EN
                        ptr_q   <= enc_q + 4'd1;
`endif
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    ack_q   <= '0;
                end
            endcase
        end
    end

    assign bus.encoderOutput = enc_q;
    assign bus.outValid      = valid_q;
    assign bus.reqAck        = ack_q;

endmodule

// File: tb/tb_encoder_16_to_4_arb.sv
// Self-checking bench for encoder_16_to_4_arb: directed stimulus pushes the
// expected grant index into a queue, a negedge monitor pops it on every
// accepted grant and tracks the expected one-cycle acknowledge.
module tb_encoder_16_to_4_arb;
    import encoder_16_to_4_arb_pkg::*;

    logic clk;
    logic clr;

    encoder_16_to_4_arb_if bus_if ();

    encoder_16_to_4_arb dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [IDX_W-1:0]   exp_q[$];
    logic [NUM_REQ-1:0] exp_ack = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 2 time units after the rising edge, well clear of the
    // negedge monitor and the next rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_drain(input string name);
        int cnt;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 60) begin
            tick();
            cnt++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: timeout, %0d grants still expected", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: compare acknowledge every cycle, and the grant index whenever
    // a grant is about to be accepted at the next rising edge.
    always @(negedge clk) begin
        if (!clr) begin
            exp_ack = '0;
        end else begin
            check("reqAck", 32'(bus_if.reqAck), 32'(exp_ack));
            exp_ack = '0;
            if (bus_if.outValid && bus_if.outReady) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_grant: got %0h, expected none", bus_if.encoderOutput);
                end else begin
                    logic [IDX_W-1:0] e;
                    e = exp_q.pop_front();
                    check("grant", 32'(bus_if.encoderOutput), 32'(e));
                    exp_ack = 16'h0001 << e;
                end
            end
        end
    end

    initial begin
        clr = 1'b0;
        bus_if.encoderInput = '0;
        bus_if.outReady     = 1'b0;
        #2;
        check("rst_valid", 32'(bus_if.outValid), 32'd0);
        check("rst_out",   32'(bus_if.encoderOutput), 32'd0);
        check("rst_ack",   32'(bus_if.reqAck), 32'd0);
        tick(2);
        clr = 1'b1;
        tick(2);

        // Single request with consumer ready
        bus_if.encoderInput = 16'h0400;
        bus_if.outReady     = 1'b1;
        exp_q.push_back(4'hA);
        tick();
        check("single_valid", 32'(bus_if.outValid), 32'd1);
        check("single_out",   32'(bus_if.encoderOutput), 32'hA);
        bus_if.encoderInput = '0;
        wait_drain("single");
        tick(3);

        // Backpressure with the request changing during the stall
        bus_if.encoderInput = 16'h0010;
        bus_if.outReady     = 1'b0;
        exp_q.push_back(4'h4);
        tick(2);
        bus_if.encoderInput = 16'h8000;
        tick(3);
        check("bp_valid", 32'(bus_if.outValid), 32'd1);
        check("bp_out",   32'(bus_if.encoderOutput), 32'h4);
        bus_if.outReady = 1'b1;
        exp_q.push_back(4'hF);
        wait_drain("backpressure");
        bus_if.encoderInput = '0;
        tick(3);

        // Multiple requests held: 8081
        bus_if.encoderInput = 16'h8081;
`ifdef ENCODER_ROUND_ROBIN_EN
        exp_q.push_back(4'h0);
        exp_q.push_back(4'h7);
        exp_q.push_back(4'hF);
        exp_q.push_back(4'h0);
`else
        exp_q.push_back(4'h0);
        exp_q.push_back(4'h0);
        exp_q.push_back(4'h0);
`endif
        wait_drain("multi_8081");
        bus_if.encoderInput = '0;
        tick(3);

        // Grant E, then 4001: rotating search from 15 wraps to 0
        bus_if.encoderInput = 16'h4000;
        exp_q.push_back(4'hE);
        wait_drain("grant_e");
        bus_if.encoderInput = 16'h4001;
`ifdef ENCODER_ROUND_ROBIN_EN
        exp_q.push_back(4'h0);
        exp_q.push_back(4'hE);
`else
        exp_q.push_back(4'h0);
        exp_q.push_back(4'h0);
`endif
        wait_drain("wrap");
        bus_if.encoderInput = '0;
        tick(3);

        // Asynchronous reset while holding grant 9
        bus_if.encoderInput = 16'h0200;
        bus_if.outReady     = 1'b0;
        tick(2);
        check("hold9_valid", 32'(bus_if.outValid), 32'd1);
        check("hold9_out",   32'(bus_if.encoderOutput), 32'h9);
        #1;
        clr = 1'b0;
        #1;
        check("arst_valid", 32'(bus_if.outValid), 32'd0);
        check("arst_out",   32'(bus_if.encoderOutput), 32'd0);
        check("arst_ack",   32'(bus_if.reqAck), 32'd0);
        bus_if.encoderInput = '0;
        tick(2);
        clr = 1'b1;
        bus_if.outReady = 1'b1;
        tick(4);
        check("end_queue", 32'(exp_q.size()), 32'd0);
        check("end_valid", 32'(bus_if.outValid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
